switch_alloc_rr: RTL

Round-robin switch allocator that drives the one-hot select lines of the router's N x M packet_t crossbar. It sits directly upstream of the crossbar and receives head-of-queue requests from the N input buffers. For each of the M output ports it grants at most one requesting input, subject to downstream readiness. It returns per-input grant pulses that pop the input buffers in the same cycle. Per-output priority pointers rotate after every grant so that no input starves.

---
 rtl/switch_alloc_rr_pkg.sv | 17 +
 rtl/switch_alloc_rr_rr_arbiter.sv | 48 ++++
 rtl/switch_alloc_rr.sv | 76 +++++++
 3 files changed

// File: rtl/switch_alloc_rr_pkg.sv
// Shared types and sizing for the round-robin switch allocator.
// Optional per-output grant counters: SWITCH_ALLOC_STATS_EN.
`ifndef N
`define N 4
`endif
`ifndef M
`define M 4
`endif

package switch_alloc_rr_pkg;

  localparam int PTR_W = (`N > 1) ? $clog2(`N) : 1;

  typedef logic [0:`M-1][0:`N-1] sel_t;
  typedef logic [0:`N-1][0:`M-1] dest_t;

endpackage

// File: rtl/switch_alloc_rr_rr_arbiter.sv
// N-input round-robin arbiter with its own rotating priority pointer.
// Pointer moves to one past the winner whenever i_en is set and a grant is made.
module rr_arbiter
  import switch_alloc_rr_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [0:`N-1] i_req,
  input  logic          i_en,
  output logic [0:`N-1] o_gnt
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] nxt;
  logic [PTR_W-1:0] idx;
  logic [PTR_W:0]   sum;
  logic             found;

  always_comb begin
    o_gnt = '0;
    nxt   = ptr;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int k = 0; k < `N; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(`N))
        sum = sum - (PTR_W+1)'(`N);
      idx = sum[PTR_W-1:0];
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        nxt = (idx == PTR_W'(`N-1)) ? '0
                                    : idx + PTR_W'(1);
      end
    end
    if (reset)
      o_gnt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (i_en)
      ptr <= nxt;
  end

endmodule

// File: rtl/switch_alloc_rr.sv
// Separable N x M round-robin switch allocator driving crossbar selects.
// Define SWITCH_ALLOC_STATS_EN to add saturating per-output grant counters.
module switch_alloc_rr
  import switch_alloc_rr_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [0:`N-1] i_req,
  input  dest_t         i_dest,
  input  logic [0:`M-1] i_ready,
  output sel_t          o_sel,
  output logic [0:`M-1] o_valid,
  output logic [0:`N-1] o_grant
`ifdef SWITCH_ALLOC_STATS_EN
  ,
  output logic [0:`M-1][15:0] o_grant_cnt
`endif
);

  sel_t req;
  sel_t gnt;
  logic hit;

  // Only the lowest-index destination bit of each input counts.
  always_comb begin
    req = '0;
    hit = 1'b0;
    for (int j = 0; j < `N; j++) begin
      hit = 1'b0;
      for (int m = 0; m < `M; m++) begin
        if (!hit && i_dest[j][m]) begin
          hit       = 1'b1;
          req[m][j] = i_req[j] & i_ready[m];
        end
      end
    end
  end

  for (genvar m = 0; m < `M; m++) begin : g_arb
    rr_arbiter u_arb (
      .clk   (clk),
      .reset (reset),
      .i_req (req[m]),
      .i_en  (i_ready[m]),
      .o_gnt (gnt[m])
    );
  end

  assign o_sel = gnt;

  always_comb begin
    o_valid = '0;
    o_grant = '0;
    for (int m = 0; m < `M; m++) begin
      o_valid[m] = |gnt[m];
      o_grant    = o_grant | gnt[m];
    end
  end

`ifdef SWITCH_ALLOC_STATS_EN
  logic [0:`M-1][15:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int m = 0; m < `M; m++)
        if (o_valid[m] && cnt[m] != 16'hFFFF)
          cnt[m] <= cnt[m] + 16'd1;
    end
  end

  assign o_grant_cnt = cnt;
`endif

endmodule
